cdb_arbiter: RTL and testbench

Parametrised completion-stage arbiter. It collects finished results from `NUM_FU` functional units and grants up to `CDB_W` of them per cycle onto the common data bus (CDB). It applies round-robin fairness and back-pressures every loser with a per-FU stall. The block sits between the FU array and the CDB/ROB/RS wake-up logic, and registers all CDB outputs.

---
 rtl/cdb_arbiter.sv | 92 +++++++++
 tb/tb_cdb_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin completion arbiter that grants up to CDB_W of NUM_FU
// finished results per cycle onto registered CDB channels and stalls the losers.
module cdb_arbiter #(
    parameter int NUM_FU = 8,
    parameter int CDB_W  = 3,
    parameter int XLEN   = 32,
    parameter int PR_W   = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic [NUM_FU-1:0]             fu_finish,
    input  logic [NUM_FU-1:0][PR_W-1:0]   fu_dest_pr,
    input  logic [NUM_FU-1:0][XLEN-1:0]   fu_dest_value,
    input  logic [NUM_FU-1:0]             fu_take_branch,
    output logic [NUM_FU-1:0]             fu_c_stall,
    output logic [CDB_W-1:0]              cdb_valid,
    output logic [CDB_W-1:0][PR_W-1:0]    cdb_tag,
    output logic [CDB_W-1:0][XLEN-1:0]    cdb_value,
    output logic [CDB_W-1:0]              cdb_take_branch
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]            rr_ptr;
    logic [PTR_W-1:0]            next_ptr;
    logic [NUM_FU-1:0]           grant;
    logic [CDB_W-1:0]            chan_valid;
    logic [CDB_W-1:0][PTR_W-1:0] chan_sel;
    logic                        arb_en;
    int                          n_grant;
    int                          scan_idx;

    // Squash and reset both suppress every grant; only reset keeps losers stalled.
    assign arb_en = reset & ~squash;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        grant      = '0;
        chan_valid = '0;
        chan_sel   = '0;
        next_ptr   = rr_ptr;
        n_grant    = 0;
        scan_idx   = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_FU;
            if (arb_en && fu_finish[scan_idx] && (n_grant < CDB_W)) begin
                grant[scan_idx]     = 1'b1;
                chan_valid[n_grant] = 1'b1;
                chan_sel[n_grant]   = PTR_W'(scan_idx);
                next_ptr            = PTR_W'((scan_idx + 1) % NUM_FU);
                n_grant             = n_grant + 1;
            end
        end
    end

    always_comb begin
        if (!reset) begin
            fu_c_stall = fu_finish;
        end else if (squash) begin
            fu_c_stall = '0;
        end else begin
            fu_c_stall = fu_finish & ~grant;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            rr_ptr          <= '0;
            cdb_valid       <= '0;
            cdb_tag         <= '0;
            cdb_value       <= '0;
            cdb_take_branch <= '0;
        end else begin
            rr_ptr <= next_ptr;
            for (int c = 0; c < CDB_W; c++) begin
                cdb_valid[c] <= chan_valid[c];
                if (chan_valid[c]) begin
                    cdb_tag[c]         <= fu_dest_pr[chan_sel[c]];
                    cdb_value[c]       <= fu_dest_value[chan_sel[c]];
                    cdb_take_branch[c] <= fu_take_branch[chan_sel[c]];
                end else begin
                    cdb_tag[c]         <= '0;
                    cdb_value[c]       <= '0;
                    cdb_take_branch[c] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios then randomized traffic,
// compared against a queue-based round-robin reference model.
module tb_cdb_arbiter;

    localparam int N          = 8;
    localparam int W          = 3;
    localparam int XLEN       = 32;
    localparam int PR_W       = 6;
    localparam int FAIR_BOUND = (N + W - 1) / W;

    logic                  clock;
    logic                  reset;
    logic                  squash;
    logic [N-1:0]          fu_finish;
    logic [N-1:0][PR_W-1:0] fu_dest_pr;
    logic [N-1:0][XLEN-1:0] fu_dest_value;
    logic [N-1:0]          fu_take_branch;
    logic [N-1:0]          fu_c_stall;
    logic [W-1:0]          cdb_valid;
    logic [W-1:0][PR_W-1:0] cdb_tag;
    logic [W-1:0][XLEN-1:0] cdb_value;
    logic [W-1:0]          cdb_take_branch;

    int           checks   = 0;
    int           failures = 0;
    int           m_ptr;
    int           m_next;
    logic [N-1:0] e_stall;
    logic [W-1:0] e_valid;
    int           e_sel [W];
    int           wait_cnt [N];

    cdb_arbiter #(.NUM_FU(N), .CDB_W(W), .XLEN(XLEN), .PR_W(PR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .squash         (squash),
        .fu_finish      (fu_finish),
        .fu_dest_pr     (fu_dest_pr),
        .fu_dest_value  (fu_dest_value),
        .fu_take_branch (fu_take_branch),
        .fu_c_stall     (fu_c_stall),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .cdb_take_branch(cdb_take_branch)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Requesters listed in priority order from the pointer; the first W win.
    task automatic ref_arbitrate();
        int order[$];
        order   = {};
        e_stall = '0;
        e_valid = '0;
        m_next  = m_ptr;
        for (int c = 0; c < W; c++) e_sel[c] = 0;
        for (int d = 0; d < N; d++) begin
            if (fu_finish[(m_ptr + d) % N]) order.push_back((m_ptr + d) % N);
        end
        if (!reset) begin
            e_stall = fu_finish;
        end else if (!squash) begin
            for (int g = 0; g < order.size(); g++) begin
                if (g < W) begin
                    e_valid[g] = 1'b1;
                    e_sel[g]   = order[g];
                    m_next     = (order[g] + 1) % N;
                end else begin
                    e_stall[order[g]] = 1'b1;
                end
            end
        end
    endtask

    task automatic update_fairness();
        logic granted;
        for (int i = 0; i < N; i++) begin
            if (reset && !squash && fu_finish[i]) begin
                granted = 1'b0;
                for (int c = 0; c < W; c++) begin
                    if (e_valid[c] && e_sel[c] == i) granted = 1'b1;
                end
                if (granted) begin
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i]++;
                    check($sformatf("fair_fu%0d", i), 64'(wait_cnt[i] < FAIR_BOUND), 64'd1);
                end
            end else begin
                wait_cnt[i] = 0;
            end
        end
    endtask

    task automatic new_data(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                fu_dest_pr[i]     = PR_W'($urandom);
                fu_dest_value[i]  = $urandom;
                fu_take_branch[i] = 1'($urandom);
            end
        end
    endtask

    // One cycle: drive, check stall combinationally, then check registered CDB after the edge.
    task automatic step(input logic r, input logic sq, input logic [N-1:0] f);
        logic [W-1:0][PR_W-1:0] x_tag;
        logic [W-1:0][XLEN-1:0] x_val;
        logic [W-1:0]           x_br;
        reset     = r;
        squash    = sq;
        fu_finish = f;
        #1;
        ref_arbitrate();
        check("fu_c_stall", 64'(fu_c_stall), 64'(e_stall));
        update_fairness();
        for (int c = 0; c < W; c++) begin
            x_tag[c] = e_valid[c] ? fu_dest_pr[e_sel[c]]     : '0;
            x_val[c] = e_valid[c] ? fu_dest_value[e_sel[c]]  : '0;
            x_br[c]  = e_valid[c] ? fu_take_branch[e_sel[c]] : 1'b0;
        end
        @(posedge clock);
        #1;
        m_ptr = r ? m_next : 0;
        check("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
        check("cdb_valid", 64'(cdb_valid), 64'(e_valid));
        for (int c = 0; c < W; c++) begin
            if (e_valid[c] || !r) begin
                check($sformatf("cdb_tag[%0d]", c), 64'(cdb_tag[c]), 64'(x_tag[c]));
                check($sformatf("cdb_value[%0d]", c), 64'(cdb_value[c]), 64'(x_val[c]));
                check($sformatf("cdb_br[%0d]", c), 64'(cdb_take_branch[c]), 64'(x_br[c]));
            end
        end
    endtask

    initial begin
        logic [PR_W-1:0] tag3;
        logic [PR_W-1:0] tag5;
        logic [N-1:0]    f;
        reset          = 1'b0;
        squash         = 1'b0;
        fu_finish      = '0;
        fu_dest_pr     = '0;
        fu_dest_value  = '0;
        fu_take_branch = '0;
        m_ptr          = 0;
        e_stall        = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        @(posedge clock);
        #1;

        // Reset held two cycles with every FU requesting.
        new_data('1);
        step(1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 8'hFF);

        // Full load from rr_ptr=0.
        new_data('1);
        step(1'b1, 1'b0, 8'hFF);
        check("full_ptr0", 64'(dut.rr_ptr), 64'd3);
        step(1'b1, 1'b0, 8'hF8);
        check("full_ptr1", 64'(dut.rr_ptr), 64'd6);
        step(1'b1, 1'b0, 8'hC0);
        check("full_valid2", 64'(cdb_valid), 64'b011);
        check("full_ptr2", 64'(dut.rr_ptr), 64'd0);

        // Sparse request.
        new_data('1);
        step(1'b1, 1'b0, 8'b0101_0111);
        check("sparse_ptr0", 64'(dut.rr_ptr), 64'd3);
        step(1'b1, 1'b0, 8'b0101_0000);
        check("sparse_valid1", 64'(cdb_valid), 64'b011);
        check("sparse_ptr1", 64'(dut.rr_ptr), 64'd7);

        // Mid-operation reset after the pointer has reached 6.
        step(1'b0, 1'b0, 8'h00);
        new_data('1);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 8'hF8);
        check("mr_ptr_pre", 64'(dut.rr_ptr), 64'd6);
        new_data('1);
        tag3 = fu_dest_pr[3];
        tag5 = fu_dest_pr[5];
        step(1'b0, 1'b1, 8'h28);
        check("mr_ptr_rst", 64'(dut.rr_ptr), 64'd0);
        step(1'b1, 1'b0, 8'h28);
        check("mr_ch0_fu3", 64'(cdb_tag[0]), 64'(tag3));
        check("mr_ch1_fu5", 64'(cdb_tag[1]), 64'(tag5));

        // Wrap-around from rr_ptr=6.
        new_data('1);
        fu_dest_value[7]  = 32'h8251dabe;
        fu_take_branch[7] = 1'b1;
        step(1'b1, 1'b0, 8'b1010_0001);
        check("wrap_val", 64'(cdb_value[0]), 64'h8251dabe);
        check("wrap_br", 64'(cdb_take_branch[0]), 64'd1);
        check("wrap_ptr", 64'(dut.rr_ptr), 64'd6);

        // Squash with full load.
        new_data('1);
        step(1'b1, 1'b1, 8'hFF);
        check("squash_valid", 64'(cdb_valid), 64'd0);
        check("squash_ptr", 64'(dut.rr_ptr), 64'd6);

        // Randomized traffic; stalled FUs hold request and data.
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (e_stall[i]) begin
                    f[i] = 1'b1;
                end else begin
                    f[i] = ($urandom_range(0, 99) < 65);
                    new_data(N'(1) << i);
                end
            end
            step($urandom_range(0, 49) != 0, $urandom_range(0, 15) == 0, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
